// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel countdown timer: channel state encoding,
// default count width and the prescaler divide-ratio helper.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned CNT_W_DEFAULT = 5;

  // Zero tick rate yields DIV=0 so the top-level range check rejects it.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned tick_hz);
    if (tick_hz == 0) return 0;
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: loads on start, decrements on unpaused ticks, and flags
// expiry either as a held level (one-shot) or a single-cycle pulse (auto-reload).
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] value,
  input  logic             tick,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             expired
);

  state_t           state, state_next;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] reload_reg, reload_next;
  logic             expired_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      expired    <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      reload_reg <= reload_next;
      expired    <= expired_next;
    end
  end

  always_comb begin
    state_next   = state;
    count_next   = count;
    reload_next  = reload_reg;
    expired_next = expired;
    if (start) begin
      // A load wins over any tick arriving in the same cycle.
      count_next   = value;
      reload_next  = value;
      state_next   = (value != '0) ? RUN : DONE;
      expired_next = (value == '0);
    end else begin
      case (state)
        RUN: begin
          expired_next = 1'b0;
          if (tick && !pause) begin
            if (count > CNT_W'(1)) begin
              count_next = count - CNT_W'(1);
            end else if (auto_reload && reload_reg != '0) begin
              count_next   = reload_reg;
              expired_next = 1'b1;
            end else begin
              count_next   = '0;
              state_next   = DONE;
              expired_next = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy = (state == RUN);
  end

endmodule

// File: rtl/multi_countdown_timer.sv
// N-channel countdown timer sharing one free-running tick prescaler; the registered
// tick strobe is both exported and fed to every channel.
module multi_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 1,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT,
  parameter int unsigned N_CH    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_CH-1:0]       start,
  input  logic [N_CH*CNT_W-1:0] value,
  input  logic [N_CH-1:0]       pause,
  input  logic [N_CH-1:0]       auto_reload,
  output logic                  one_hz_enable,
  output logic [N_CH*CNT_W-1:0] count,
  output logic [N_CH-1:0]       busy,
  output logic [N_CH-1:0]       expired
);

  localparam int unsigned DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_bad_div
    $error("multi_countdown_timer: CLK_HZ/TICK_HZ must be at least 2");
  end

  logic [PW-1:0] prescaler;
  logic          wrap;

  always_comb begin
    wrap = (prescaler == PW'(DIV - 1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler     <= '0;
      one_hz_enable <= 1'b0;
    end else begin
      prescaler     <= wrap ? '0 : prescaler + PW'(1);
      one_hz_enable <= wrap;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    timer_channel #(.CNT_W(CNT_W)) u_channel (
      .clock       (clock),
      .reset       (reset),
      .start       (start[i]),
      .value       (value[i*CNT_W +: CNT_W]),
      .tick        (one_hz_enable),
      .pause       (pause[i]),
      .auto_reload (auto_reload[i]),
      .count       (count[i*CNT_W +: CNT_W]),
      .busy        (busy[i]),
      .expired     (expired[i])
    );
  end

endmodule

// File: tb/tb_multi_countdown_timer.sv
// Self-checking bench for multi_countdown_timer (DIV=10, 5-bit counts, 2 channels)
// against a cycle-level behavioural model of the timer rules.
module tb_multi_countdown_timer;

  localparam int unsigned W  = 5;
  localparam int unsigned NC = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [NC-1:0]   start = '0;
  logic [NC*W-1:0] value = '0;
  logic [NC-1:0]   pause = '0;
  logic [NC-1:0]   auto_reload = '0;
  logic            one_hz_enable;
  logic [NC*W-1:0] count;
  logic [NC-1:0]   busy;
  logic [NC-1:0]   expired;

  int passed = 0;
  int total  = 0;

  // Model: ticks are visible in the cycle after every 10th clock edge since reset.
  int unsigned m_edges;
  bit          m_tick;
  int          m_cnt [NC];
  int          m_rel [NC];
  bit          m_run [NC];
  bit          m_exp [NC];

  multi_countdown_timer #(
    .CLK_HZ(10), .TICK_HZ(1), .CNT_W(W), .N_CH(NC)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .value(value), .pause(pause),
    .auto_reload(auto_reload), .one_hz_enable(one_hz_enable), .count(count),
    .busy(busy), .expired(expired)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    m_edges = 0;
    m_tick  = 0;
    for (int c = 0; c < NC; c++) begin
      m_cnt[c] = 0; m_rel[c] = 0; m_run[c] = 0; m_exp[c] = 0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < NC; c++) begin
      int v;
      v = int'(value[c*W +: W]);
      if (start[c]) begin
        m_cnt[c] = v; m_rel[c] = v; m_run[c] = (v != 0); m_exp[c] = (v == 0);
      end else if (m_run[c]) begin
        m_exp[c] = 0;
        if (m_tick && !pause[c]) begin
          if (m_cnt[c] > 1) m_cnt[c] = m_cnt[c] - 1;
          else if (auto_reload[c] && m_rel[c] != 0) begin
            m_cnt[c] = m_rel[c]; m_exp[c] = 1;
          end else begin
            m_cnt[c] = 0; m_run[c] = 0; m_exp[c] = 1;
          end
        end
      end
    end
    m_edges++;
    m_tick = (m_edges % 10 == 0);
  endtask

  function automatic logic [14:0] exp_vec();
    return {m_tick, 5'(m_cnt[1]), 5'(m_cnt[0]), m_run[1], m_run[0], m_exp[1], m_exp[0]};
  endfunction

  function automatic logic [14:0] obs_vec();
    return {one_hz_enable, count, busy, expired};
  endfunction

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    total++;
    if (obs_vec() !== 15'd0) $display("FAIL reset_state got=%h want=%h", obs_vec(), 15'd0);
    else passed++;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_prescaler();
    for (int k = 0; k < 30; k++) begin
      step();
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL prescaler k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
      else passed++;
    end
  endtask

  task automatic test_oneshot();
    auto_reload[0] = 1'b0;
    start[0] = 1'b1; value[0 +: W] = 5'd3;
    step();
    start[0] = 1'b0; value[0 +: W] = 5'd17;
    for (int k = 0; k < 45; k++) begin
      step();
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL oneshot k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
      else passed++;
    end
    total++;
    if ({count[0 +: W], busy[0], expired[0]} !== {5'd0, 1'b0, 1'b1})
      $display("FAIL oneshot_done got=%h want=%h", {count[0 +: W], busy[0], expired[0]}, {5'd0, 1'b0, 1'b1});
    else passed++;
  endtask

  task automatic test_reload();
    auto_reload[1] = 1'b1;
    start[1] = 1'b1; value[W +: W] = 5'd2;
    step();
    start[1] = 1'b0;
    for (int k = 0; k < 60; k++) begin
      step();
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL reload k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
      else passed++;
    end
    auto_reload[1] = 1'b0;
  endtask

  task automatic test_pause();
    bit found;
    start[0] = 1'b1; value[0 +: W] = 5'd6;
    step();
    start[0] = 1'b0;
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      step();
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL pause_run k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
      else passed++;
      found = (m_cnt[0] == 4 && m_run[0]);
    end
    total++;
    if (!found) $display("FAIL pause_reach got=%0d want=%0d", m_cnt[0], 4);
    else passed++;
    pause[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL pause_hold k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
      else passed++;
    end
    total++;
    if (count[0 +: W] !== 5'd4) $display("FAIL pause_held got=%0d want=%0d", count[0 +: W], 4);
    else passed++;
    pause[0] = 1'b0;
    repeat (10) step();
    total++;
    if (count[0 +: W] !== 5'd3) $display("FAIL pause_resume got=%0d want=%0d", count[0 +: W], 3);
    else passed++;
  endtask

  task automatic test_start_on_tick();
    start[0] = 1'b1; value[0 +: W] = 5'd5;
    step();
    start[0] = 1'b0;
    for (int k = 0; k < 12 && !m_tick; k++) step();
    total++;
    if ({one_hz_enable, count[0 +: W]} !== {1'b1, 5'd5})
      $display("FAIL tick_align got=%h want=%h", {one_hz_enable, count[0 +: W]}, {1'b1, 5'd5});
    else passed++;
    start[0] = 1'b1; value[0 +: W] = 5'd9;
    step();
    start[0] = 1'b0;
    total++;
    if ({count[0 +: W], busy[0]} !== {5'd9, 1'b1})
      $display("FAIL start_over_tick got=%h want=%h", {count[0 +: W], busy[0]}, {5'd9, 1'b1});
    else passed++;
  endtask

  task automatic test_zero_start();
    start[1] = 1'b1; value[W +: W] = 5'd0;
    step();
    start[1] = 1'b0;
    total++;
    if ({count[W +: W], busy[1], expired[1]} !== {5'd0, 1'b0, 1'b1})
      $display("FAIL zero_start got=%h want=%h", {count[W +: W], busy[1], expired[1]}, {5'd0, 1'b0, 1'b1});
    else passed++;
    for (int k = 0; k < 15; k++) begin
      step();
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL zero_hold k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < NC; c++) begin
        start[c] = ($urandom_range(0, 29) == 0);
        value[c*W +: W] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 6));
        pause[c] = ($urandom_range(0, 4) == 0);
        if ($urandom_range(0, 19) == 0) auto_reload[c] = ~auto_reload[c];
      end
      step();
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL random k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
      else passed++;
    end
    start = '0;
    pause = '0;
  endtask

  task automatic test_reset_midrun();
    auto_reload = '0;
    start = '1; value = {5'd7, 5'd8};
    step();
    start = '0;
    repeat (13) step();
    reset = 1'b1;
    #1;
    total++;
    if (obs_vec() !== 15'd0) $display("FAIL reset_midrun got=%h want=%h", obs_vec(), 15'd0);
    else passed++;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 25; k++) begin
      step();
      total++;
      if (obs_vec() !== exp_vec()) $display("FAIL after_reset k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
      else passed++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_prescaler();
    test_oneshot();
    test_reload();
    test_pause();
    test_start_on_tick();
    test_zero_start();
    test_random();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
